// File: rtl/ss_sequencer.sv
// Save-state sequencer: walks a mapper's save-state register window and moves
// each byte to (save) or from (load) a byte-wide snapshot buffer through a
// request/acknowledge port. Load verifies the mapper index before any write.
module ss_sequencer #(
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned IDX_ADDR  = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_save,
    input  logic       start_load,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic       buf_req,
    output logic       buf_wr,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdat,
    input  logic [7:0] buf_rdat,
    input  logic       buf_ack
);

    localparam logic [7:0] LastReg = 8'(REG_COUNT - 1);
    localparam logic [7:0] IdxAddr = 8'(IDX_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StChk,
        StSrd,
        StSwr,
        StLrd,
        StLwr,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] ss_wdat_q, ss_wdat_d;
    logic [7:0] buf_wdat_q, buf_wdat_d;
    logic       err_q, err_d;
    // Remembers an abort seen while a buffer handshake is still outstanding.
    logic       abort_q, abort_d;
    logic       stop;

    assign stop = abort | abort_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ss_wdat_d  = ss_wdat_q;
        buf_wdat_d = buf_wdat_q;
        err_d      = err_q;
        abort_d    = 1'b0;
        case (state_q)
            StIdle: begin
                // Save wins over a simultaneous load request.
                if (start_save) begin
                    state_d = StSrd;
                    addr_d  = 8'd0;
                    err_d   = 1'b0;
                end else if (start_load) begin
                    state_d = StChk;
                    addr_d  = IdxAddr;
                    err_d   = 1'b0;
                end
            end
            StSrd: begin
                if (abort) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    buf_wdat_d = ss_rdat;
                    state_d    = StSwr;
                end
            end
            StSwr: begin
                abort_d = stop;
                if (buf_ack) begin
                    abort_d = 1'b0;
                    if (stop) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (addr_q == IdxAddr) begin
                        state_d = StDone;
                    end else if (addr_q < LastReg) begin
                        addr_d  = addr_q + 8'd1;
                        state_d = StSrd;
                    end else begin
                        addr_d  = IdxAddr;
                        state_d = StSrd;
                    end
                end
            end
            StChk: begin
                abort_d = stop;
                if (buf_ack) begin
                    abort_d = 1'b0;
                    if (stop || (buf_rdat != ss_rdat)) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        addr_d  = 8'd0;
                        state_d = StLrd;
                    end
                end
            end
            StLrd: begin
                abort_d = stop;
                if (buf_ack) begin
                    abort_d = 1'b0;
                    if (stop) begin
                        // Acked byte is dropped so no further mapper write happens.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        ss_wdat_d = buf_rdat;
                        state_d   = StLwr;
                    end
                end
            end
            StLwr: begin
                if (abort) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (addr_q < LastReg) begin
                    addr_d  = addr_q + 8'd1;
                    state_d = StLrd;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 8'd0;
            ss_wdat_q  <= 8'd0;
            buf_wdat_q <= 8'd0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            ss_wdat_q  <= ss_wdat_d;
            buf_wdat_q <= buf_wdat_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        ss_act   = (state_q != StIdle);
        ss_we    = (state_q == StLwr);
        buf_req  = (state_q == StSwr) || (state_q == StChk) || (state_q == StLrd);
        buf_wr   = (state_q == StSwr);
        ss_addr  = addr_q;
        buf_addr = addr_q;
        ss_wdat  = ss_wdat_q;
        buf_wdat = buf_wdat_q;
        err      = err_q;
    end

endmodule

// File: doc/ss_sequencer.md
# ss_sequencer

Save-state sequencer for mapper cores. It walks a mapper's save-state register window (`ss_act`/`ss_we`/`ss_addr`/`ss_rdat`) and transfers each register byte to or from a byte-wide snapshot buffer through a request/acknowledge port. It sits between the system save-state controller and the active mapper. On save it dumps registers 0..REG_COUNT-1 plus the mapper-index slot; on load it first verifies the mapper index and then restores registers 0..REG_COUNT-1.

## Interface
Parameters:
- `REG_COUNT`, 16: number of contiguous state registers, at addresses 0..REG_COUNT-1; range 1..127.
- `IDX_ADDR`, 127: save-state address of the read-only mapper-index byte.

Ports:
- `clk`  in  1  system clock; all state updates occur on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_save`  in  1  one-cycle request to snapshot the mapper into the buffer.
- `start_load`  in  1  one-cycle request to restore the mapper from the buffer.
- `abort`  in  1  cancels the operation in progress.
- `busy`  out  1  high from the accepting edge until the cycle after `done`.
- `done`  out  1  one-cycle completion pulse; also pulses on abort.
- `err`  out  1  sticky; set on index mismatch or abort; cleared by the next accepted start.
- `ss_act`  out  1  save-state window select to the mapper.
- `ss_we`  out  1  mapper register write strobe, one cycle per byte.
- `ss_addr`  out  8  mapper save-state register address.
- `ss_wdat`  out  8  byte written to the mapper; drives the mapper's data input while `ss_act` is high.
- `ss_rdat`  in  8  mapper readback; combinational from `ss_addr`.
- `buf_req`  out  1  buffer access request.
- `buf_wr`  out  1  access direction: 1 = write, 0 = read.
- `buf_addr`  out  8  buffer byte address; always equals `ss_addr`.
- `buf_wdat`  out  8  buffer write data.
- `buf_rdat`  in  8  buffer read data; valid in the cycle `buf_ack` is high.
- `buf_ack`  in  1  access complete; sampled on the rising edge while `buf_req` is high.

## Operation
- **States:** IDLE, CHK, SRD, SWR, LRD, LWR, DONE.
- **IDLE**
  - `start_save` → SRD with address 0.
  - Otherwise `start_load` → CHK with address IDX_ADDR.
  - Both asserted together: save wins and load is dropped.
  - Starts received outside IDLE are ignored.
- **SRD (save):** holds `ss_act` high and `ss_addr` at the current address for one settle cycle. Then it latches `ss_rdat` into `buf_wdat` and moves to SWR.
- **SWR:** holds `buf_req`=1 and `buf_wr`=1 until `buf_ack`. On ack, the next state depends on the current address:
  - address < REG_COUNT-1 → increment address, back to SRD.
  - address = REG_COUNT-1 → set address to IDX_ADDR, back to SRD.
  - address = IDX_ADDR → DONE.
- **CHK (load):** `ss_addr`=IDX_ADDR, with `buf_req`=1 and `buf_wr`=0. On ack, `buf_rdat` is compared with `ss_rdat`:
  - Equal → address 0, go to LRD.
  - Unequal → set `err`, go to DONE. No mapper write occurs.
- **LRD:** buffer read at the current address. On ack, latch `buf_rdat` into `ss_wdat` and go to LWR.
- **LWR:** `ss_we`=1 for exactly one cycle, with `ss_addr` and `ss_wdat` stable.
  - address < REG_COUNT-1 → increment, back to LRD.
  - Otherwise → DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **`ss_act`:** high in every state except IDLE. It stays high continuously for the whole operation, with no gaps between bytes.
- **`abort`:**
  - Sampled high outside IDLE while no `buf_req` is pending → DONE with `err`=1.
  - While `buf_req` is high, the sequencer finishes that handshake first; the acked data is discarded and no further `ss_we` is issued.
  - `abort` in IDLE has no effect.
- **Address counter:** 8-bit. Increments never pass REG_COUNT-1 and the counter never wraps.

## Timing
- **Reset:** asynchronous assertion forces state to IDLE. All outputs go to 0: `busy`, `done`, `err`, `ss_act`, `ss_we`, `ss_addr`=0, `ss_wdat`=0, `buf_req`, `buf_wr`, `buf_wdat`=0. Reset mid-operation abandons the transfer immediately with no `done` pulse.
- **Save, zero-wait buffer (`buf_ack` high on the first request cycle):** 2 cycles per byte over REG_COUNT+1 bytes, plus 1 DONE cycle. That is 35 cycles for REG_COUNT=16, counted from the start-sampling edge.
- **Load, zero-wait buffer:** 1 cycle for CHK, 2 cycles per register, plus 1 DONE cycle. That is 34 cycles for REG_COUNT=16.
- **Each buffer wait state** adds exactly one cycle.
- **`busy`** rises on the edge that samples the start request and falls on the edge that leaves DONE.
- **Request signals:** `buf_req`, `buf_addr`, `buf_wr` and `buf_wdat` stay stable from request assertion through the ack edge. `buf_req` drops in the cycle after ack.

## Test plan
- **Save:** mapper model holds register k = 0x10+k and index 0x23; `buf_ack` tied high; pulse `start_save` → buffer[0..15] = 0x10..0x1F, buffer[127] = 0x23, `done` at cycle 35, `err`=0.
- **Load match:** buffer[127] = 0x23, buffer[k] = 0xA0+k, mapper index 0x23 → 16 `ss_we` pulses writing 0xA0..0xAF to addresses 0..15 in order, `done` at cycle 34, `err`=0.
- **Load mismatch:** buffer[127] = 0x24 → zero `ss_we` pulses, `done` at cycle 2, `err`=1.
- **Backpressure:** `buf_ack` delayed 3 cycles on every access during save → request signals stable while waiting, `done` at cycle 35 + 3×17 = 86.
- **Abort:** assert `abort` during load at address 5 while in LWR → address 5 written, address 6 never written, `done` plus `err`=1, IDLE afterwards; a following `start_save` clears `err`.
- **Simultaneous start and reset:** `start_save` and `start_load` in the same cycle → save performed. `rst_n` low mid-save → all outputs 0 immediately and no `done` pulse.
